// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional ALU_ARB_FLAGS_EN adds registered rsp_zero/rsp_neg result flags.
module alu_req_arbiter #(
  parameter int DW        = 32,
  parameter int OPW       = 5,
  parameter int PRIO_INIT = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  input  logic [OPW-1:0] req0_op,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  input  logic [OPW-1:0] req1_op,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [DW-1:0]  rsp_data,
`ifdef ALU_ARB_FLAGS_EN
  output logic           rsp_zero,
  output logic           rsp_neg,
`endif
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [DW-1:0]  alu_out,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   prio;
  logic   owner;
  logic   gnt0;
  logic   gnt1;
  logic   rsp_hs;
  logic   idle;

  // prio only matters when both requesters contend
  assign gnt0 = req0_valid & (~req1_valid | ~prio);
  assign gnt1 = req1_valid & (~req0_valid | prio);
  assign idle = (state == IDLE);

  assign req0_ready = rst_n & idle & gnt0;
  assign req1_ready = rst_n & idle & gnt1;

  assign rsp_hs = (rsp0_valid & rsp0_ready)
                | (rsp1_valid & rsp1_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      prio       <= (PRIO_INIT != 0);
      owner      <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_data   <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      busy       <= 1'b0;
`ifdef ALU_ARB_FLAGS_EN
      rsp_zero   <= 1'b0;
      rsp_neg    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (req0_ready) begin
            owner  <= 1'b0;
            alu_a  <= req0_a;
            alu_b  <= req0_b;
            alu_op <= req0_op;
            state  <= EXEC;
            busy   <= 1'b1;
          end else if (req1_ready) begin
            owner  <= 1'b1;
            alu_a  <= req1_a;
            alu_b  <= req1_b;
            alu_op <= req1_op;
            state  <= EXEC;
            busy   <= 1'b1;
          end
        end
        EXEC: begin
          rsp_data   <= alu_out;
`ifdef ALU_ARB_FLAGS_EN
          rsp_zero   <= (alu_out == '0);
          rsp_neg    <= alu_out[DW-1];
`endif
          alu_op     <= '0;
          rsp0_valid <= ~owner;
          rsp1_valid <= owner;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_hs) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            prio       <= ~owner;
            state      <= IDLE;
            busy       <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Scoreboard bench for alu_req_arbiter: directed corners plus random traffic.
// Flag outputs are checked when ALU_ARB_FLAGS_EN is defined.
module tb_alu_req_arbiter;

  localparam int DW = 32;
  localparam int OPW = 5;
  localparam int PRIO_INIT = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic req0_ready, req1_ready;
  logic [DW-1:0] req0_a = '0, req0_b = '0;
  logic [DW-1:0] req1_a = '0, req1_b = '0;
  logic [OPW-1:0] req0_op = '0, req1_op = '0;
  logic rsp0_valid, rsp1_valid;
  logic rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic [DW-1:0] alu_a, alu_b, alu_out;
  logic [OPW-1:0] alu_op;
  logic busy;
`ifdef ALU_ARB_FLAGS_EN
  logic rsp_zero, rsp_neg;
`endif

  always #5 clk = ~clk;

  // Reference ALU semantics from the opcode table
  function automatic logic [DW-1:0] ref_alu(
    input logic [DW-1:0] a, input logic [DW-1:0] b,
    input logic [OPW-1:0] op);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      5'd1: return DW'(sa + sb);
      5'd2: return DW'(sa - sb);
      5'd3: return a & b;
      5'd4: return a | b;
      5'd5: return a ^ b;
      5'd6: return ~(a | b);
      default: return '0;
    endcase
  endfunction

  assign alu_out = ref_alu(alu_a, alu_b, alu_op);

  alu_req_arbiter #(.DW(DW), .OPW(OPW), .PRIO_INIT(PRIO_INIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data),
`ifdef ALU_ARB_FLAGS_EN
    .rsp_zero(rsp_zero), .rsp_neg(rsp_neg),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .busy(busy)
  );

  typedef struct {
    bit            own;
    logic [DW-1:0] res;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  bit  mprio = (PRIO_INIT != 0);
  bit  acc0 = 0, acc1 = 0;
  bit  rnd_en = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: model arbitration/latency, push on accept, pop on response
  always @(negedge clk) begin
    if (rst_n) begin
      bit empty, er0, er1, e0, e1;
      exp_t e;
      cyc++;
      empty = (q.size() == 0);
      er0 = empty && req0_valid && (!req1_valid || !mprio);
      er1 = empty && req1_valid && (!req0_valid || mprio);
      chk("req0_ready", DW'(req0_ready), DW'(er0));
      chk("req1_ready", DW'(req1_ready), DW'(er1));
      chk("busy", DW'(busy), DW'(!empty));
      if (empty) chk("alu_op_idle_nop", DW'(alu_op), '0);
      e0 = 0;
      e1 = 0;
      if (!empty && cyc >= q[0].cyc + 2) begin
        e0 = !q[0].own;
        e1 = q[0].own;
      end
      chk("rsp0_valid", DW'(rsp0_valid), DW'(e0));
      chk("rsp1_valid", DW'(rsp1_valid), DW'(e1));
      if (e0 || e1) begin
        chk("rsp_data", rsp_data, q[0].res);
`ifdef ALU_ARB_FLAGS_EN
        chk("rsp_zero", DW'(rsp_zero), DW'(q[0].res == '0));
        chk("rsp_neg", DW'(rsp_neg), DW'(q[0].res[DW-1]));
`endif
      end
      if (!empty && ((rsp0_valid && rsp0_ready) ||
                     (rsp1_valid && rsp1_ready))) begin
        mprio = ~q[0].own;
        void'(q.pop_front());
      end
      if (req0_valid && req0_ready) begin
        e.own = 0;
        e.res = ref_alu(req0_a, req0_b, req0_op);
        e.cyc = cyc;
        q.push_back(e);
        acc0 = 1;
      end else if (req1_valid && req1_ready) begin
        e.own = 1;
        e.res = ref_alu(req1_a, req1_b, req1_op);
        e.cyc = cyc;
        q.push_back(e);
        acc1 = 1;
      end
    end
  end

  function automatic logic [DW-1:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return '0;
      3: return '1;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [OPW-1:0] rnd_op();
    if ($urandom_range(0, 7) == 0) return OPW'($urandom_range(7, 31));
    return OPW'($urandom_range(0, 6));
  endfunction

  // Random traffic driver
  always @(posedge clk) begin
    if (rnd_en) begin
      #1;
      if (acc0) begin req0_valid = 0; acc0 = 0; end
      if (acc1) begin req1_valid = 0; acc1 = 0; end
      if (!req0_valid && $urandom_range(0, 2) == 0) begin
        req0_valid = 1; req0_a = rnd_opnd(); req0_b = rnd_opnd();
        req0_op = rnd_op();
      end else if (req0_valid && $urandom_range(0, 15) == 0) begin
        req0_valid = 0;
      end
      if (!req1_valid && $urandom_range(0, 2) == 0) begin
        req1_valid = 1; req1_a = rnd_opnd(); req1_b = rnd_opnd();
        req1_op = rnd_op();
      end else if (req1_valid && $urandom_range(0, 15) == 0) begin
        req1_valid = 0;
      end
      rsp0_ready = $urandom_range(0, 1);
      rsp1_ready = $urandom_range(0, 1);
    end
  end

  task automatic set_req(input int i, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [OPW-1:0] op);
    if (i == 0) begin
      req0_valid = 1; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = 1; req1_a = a; req1_b = b; req1_op = op;
    end
  endtask

  // Hold requests until each is accepted, bounded
  task automatic wait_accepts();
    int k;
    for (k = 0; k < 60 && (req0_valid || req1_valid); k++) begin
      @(posedge clk); #1;
      if (acc0) begin req0_valid = 0; acc0 = 0; end
      if (acc1) begin req1_valid = 0; acc1 = 0; end
    end
    if (req0_valid || req1_valid) begin
      chk("accept_timeout", 1, 0);
      req0_valid = 0;
      req1_valid = 0;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && q.size() != 0; k++) @(posedge clk);
    if (q.size() != 0) begin
      chk("drain_timeout", DW'(q.size()), 0);
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic op1(input int i, input logic [DW-1:0] a,
                     input logic [DW-1:0] b, input logic [OPW-1:0] op);
    acc0 = 0; acc1 = 0;
    set_req(i, a, b, op);
    wait_accepts();
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    req0_valid = 1;
    #3;
    chk("rst_req0_ready", DW'(req0_ready), 0);
    chk("rst_busy", DW'(busy), 0);
    chk("rst_rsp0_valid", DW'(rsp0_valid), 0);
    chk("rst_rsp1_valid", DW'(rsp1_valid), 0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_alu_a", alu_a, '0);
    chk("rst_alu_op", DW'(alu_op), '0);
    req0_valid = 0;
    #20 rst_n = 1;
    @(posedge clk); #1;

    op1(0, 32'd5, 32'd3, 5'd1);
    acc0 = 0; acc1 = 0;
    set_req(0, 32'd10, 32'd3, 5'd2);
    set_req(1, 32'hF0F0, 32'hFF00, 5'd3);
    wait_accepts();
    drain();
    acc0 = 0; acc1 = 0;
    set_req(0, 32'd1, 32'd2, 5'd4);
    set_req(1, 32'd3, 32'd5, 5'd5);
    wait_accepts();
    drain();

    rsp0_ready = 0;
    acc0 = 0;
    set_req(0, 32'd9, 32'd4, 5'd2);
    wait_accepts();
    for (k = 0; k < 20 && !rsp0_valid; k++) @(negedge clk);
    repeat (5) @(posedge clk);
    #1;
    chk("stall_busy", DW'(busy), 1);
    chk("stall_rsp0_valid", DW'(rsp0_valid), 1);
    chk("stall_rsp_data", rsp_data, 32'd5);
    rsp0_ready = 1;
    drain();

    op1(1, 32'h7FFF_FFFF, 32'd1, 5'd1);
    op1(1, 32'd0, 32'd1, 5'd2);
    op1(0, 32'd0, 32'd0, 5'd6);
    op1(1, 32'hDEAD, 32'hBEEF, 5'h1F);
    op1(0, 32'h1234, 32'h4321, 5'd0);

    acc0 = 0;
    set_req(0, 32'd5, 32'd6, 5'd1);
    wait_accepts();
    rst_n = 0;
    req0_valid = 1;
    req1_valid = 1;
    #1;
    chk("mid_rst_req0_ready", DW'(req0_ready), 0);
    chk("mid_rst_req1_ready", DW'(req1_ready), 0);
    chk("mid_rst_busy", DW'(busy), 0);
    chk("mid_rst_rsp0_valid", DW'(rsp0_valid), 0);
    chk("mid_rst_alu_a", alu_a, '0);
    chk("mid_rst_alu_op", DW'(alu_op), '0);
    chk("mid_rst_rsp_data", rsp_data, '0);
    q.delete();
    mprio = (PRIO_INIT != 0);
    acc0 = 0; acc1 = 0;
    #10 rst_n = 1;
    wait_accepts();
    drain();

    op1(0, 32'd4, 32'd4, 5'd2);
    op1(1, 32'd3, 32'd4, 5'd2);

    acc0 = 0; acc1 = 0;
    rnd_en = 1;
    repeat (3000) @(posedge clk);
    rnd_en = 0;
    #2;
    req0_valid = 0;
    req1_valid = 0;
    rsp0_ready = 1;
    rsp1_ready = 1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
